// File: rtl/taillight_stalk_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : taillight_stalk_ctrl
// Description : Driver-side command generator for the taillight sequencer.
//               Raw steering-column and pedal levels are synchronized through
//               two flops and debounced. The turn stalk is resolved through a
//               small FSM. The hazard button is converted to a toggle. All
//               commands leave as registered levels.
// Ports       : clk            - system clock, rising edge
//               rst_n          - synchronous reset, active low
//               stalk_left_i   - raw left stalk level
//               stalk_right_i  - raw right stalk level
//               hazard_btn_i   - raw hazard push-button (1 = pressed)
//               brake_pedal_i  - raw brake pedal switch
//               headlight_sw_i - raw headlight / runlight switch
//               left_o, right_o, hazard_o, brake_o, runlights_o
//                              - registered commands to the sequencer
//               turn_state_o   - turn FSM state (00 IDLE, 01 LEFT,
//                                10 RIGHT, 11 LOCKOUT)
// Option      : TAILLIGHT_STALK_CTRL_AUTOCANCEL_EN adds a turn-signal
//               timeout of CANCEL_CYCLES cycles that forces LOCKOUT.
// Revision    : 1.0 - initial release
// ============================================================================
module taillight_stalk_ctrl #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int CANCEL_CYCLES   = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       stalk_left_i,
   input  logic       stalk_right_i,
   input  logic       hazard_btn_i,
   input  logic       brake_pedal_i,
   input  logic       headlight_sw_i,
   output logic       left_o,
   output logic       right_o,
   output logic       hazard_o,
   output logic       brake_o,
   output logic       runlights_o,
   output logic [1:0] turn_state_o
);

   localparam int NUM_IN   = 5;
   localparam int IDX_LEFT = 0;
   localparam int IDX_RGHT = 1;
   localparam int IDX_HAZ  = 2;
   localparam int IDX_BRK  = 3;
   localparam int IDX_HEAD = 4;

   // Counter is 8 bits; the compare is done one bit wider so a limit of 255
   // is reached without wrap.
   localparam logic [8:0] DEB_LIMIT = 9'(DEBOUNCE_CYCLES);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'b00,
      ST_LEFT    = 2'b01,
      ST_RIGHT   = 2'b10,
      ST_LOCKOUT = 2'b11
   } state_t;

   logic [NUM_IN-1:0] raw;
   logic [NUM_IN-1:0] sync1;
   logic [NUM_IN-1:0] sync2;
   logic [NUM_IN-1:0] deb;
   logic [7:0]        deb_cnt [NUM_IN];

   state_t state;
   state_t state_nxt;
   logic   hazard_q;
   logic   hazard_nxt;
   logic   deb_hazard_d;
   logic   cancel_hit;
   logic   dl;
   logic   dr;
   logic   dh;

   assign raw = {headlight_sw_i, brake_pedal_i, hazard_btn_i,
                 stalk_right_i, stalk_left_i};

   // ------------------------------------------------------------------------
   // Synchronizers and debouncers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync1 <= '0;
         sync2 <= '0;
         deb   <= '0;
         for (int i = 0; i < NUM_IN; i++) begin
            deb_cnt[i] <= '0;
         end
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
         for (int i = 0; i < NUM_IN; i++) begin
            if (sync2[i] == deb[i]) begin
               // Agreement (or a bounce back) restarts the stability count.
               deb_cnt[i] <= '0;
            end else if ({1'b0, deb_cnt[i]} + 9'd1 == DEB_LIMIT) begin
               deb[i]     <= sync2[i];
               deb_cnt[i] <= '0;
            end else begin
               deb_cnt[i] <= deb_cnt[i] + 8'd1;
            end
         end
      end
   end

   assign dl = deb[IDX_LEFT];
   assign dr = deb[IDX_RGHT];
   assign dh = deb[IDX_HAZ];

   // ------------------------------------------------------------------------
   // Optional turn-signal timeout
   // ------------------------------------------------------------------------
`ifdef TAILLIGHT_STALK_CTRL_AUTOCANCEL_EN
   localparam logic [16:0] CANCEL_LIMIT = 17'(CANCEL_CYCLES);
   logic [15:0] cancel_cnt;

   // Fires on the cycle whose edge would bring the count to the limit, so the
   // lamp is lit for exactly CANCEL_CYCLES cycles.
   assign cancel_hit = ((state == ST_LEFT) || (state == ST_RIGHT)) &&
                       (({1'b0, cancel_cnt} + 17'd1) == CANCEL_LIMIT);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cancel_cnt <= '0;
      end else if (state_nxt != state) begin
         cancel_cnt <= '0;
      end else if ((state == ST_LEFT) || (state == ST_RIGHT)) begin
         cancel_cnt <= cancel_cnt + 16'd1;
      end
   end
`else
   // No timeout without the counter; CANCEL_CYCLES is at least 1, so this
   // expression is constant 0.
   assign cancel_hit = (CANCEL_CYCLES < 0);
`endif

   // ------------------------------------------------------------------------
   // Turn FSM next state and hazard toggle
   // ------------------------------------------------------------------------
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (dl && !dr) begin
               state_nxt = ST_LEFT;
            end else if (dr && !dl) begin
               state_nxt = ST_RIGHT;
            end
         end
         ST_LEFT: begin
            if (!dl) begin
               state_nxt = ST_IDLE;
            end else if (dr || cancel_hit) begin
               state_nxt = ST_LOCKOUT;
            end
         end
         ST_RIGHT: begin
            if (!dr) begin
               state_nxt = ST_IDLE;
            end else if (dl || cancel_hit) begin
               state_nxt = ST_LOCKOUT;
            end
         end
         ST_LOCKOUT: begin
            // The stalk must return fully to centre before a new signal.
            if (!dl && !dr) begin
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase

      // Toggle on the debounced press edge only.
      hazard_nxt = hazard_q ^ (dh & ~deb_hazard_d);
   end

   // ------------------------------------------------------------------------
   // State and registered outputs. Turn outputs are computed from the next
   // state and next hazard value so they update on the same edge as
   // turn_state_o and hazard_o and can never disagree with them.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state        <= ST_IDLE;
         hazard_q     <= 1'b0;
         deb_hazard_d <= 1'b0;
         left_o       <= 1'b0;
         right_o      <= 1'b0;
         brake_o      <= 1'b0;
         runlights_o  <= 1'b0;
      end else begin
         state        <= state_nxt;
         hazard_q     <= hazard_nxt;
         deb_hazard_d <= dh;
         left_o       <= (state_nxt == ST_LEFT)  && !hazard_nxt;
         right_o      <= (state_nxt == ST_RIGHT) && !hazard_nxt;
         brake_o      <= deb[IDX_BRK];
         runlights_o  <= deb[IDX_HEAD];
      end
   end

   assign hazard_o     = hazard_q;
   assign turn_state_o = state;

endmodule
`default_nettype wire

// File: tb/tb_taillight_stalk_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_taillight_stalk_ctrl
// Description : Self-checking bench for taillight_stalk_ctrl. Each scenario
//               drives raw levels at the falling edge and pushes the output
//               vector it expects at a given cycle onto a scoreboard queue;
//               entries are popped and compared once that cycle arrives.
//               Output vector: {left, right, hazard, brake, runlights, state}.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_taillight_stalk_ctrl;

   logic       clk;
   logic       rst_n;
   logic       stalk_left_i;
   logic       stalk_right_i;
   logic       hazard_btn_i;
   logic       brake_pedal_i;
   logic       headlight_sw_i;
   logic       left_o;
   logic       right_o;
   logic       hazard_o;
   logic       brake_o;
   logic       runlights_o;
   logic [1:0] turn_state_o;

   typedef struct {
      int         due;
      logic [6:0] exp;
      string      name;
   } exp_t;

   exp_t sb[$];
   int   cyc    = 0;
   int   checks = 0;
   int   errors = 0;

   logic [6:0] outs;
   assign outs = {left_o, right_o, hazard_o, brake_o, runlights_o, turn_state_o};

   taillight_stalk_ctrl #(
      .DEBOUNCE_CYCLES(4),
      .CANCEL_CYCLES  (16)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .stalk_left_i  (stalk_left_i),
      .stalk_right_i (stalk_right_i),
      .hazard_btn_i  (hazard_btn_i),
      .brake_pedal_i (brake_pedal_i),
      .headlight_sw_i(headlight_sw_i),
      .left_o        (left_o),
      .right_o       (right_o),
      .hazard_o      (hazard_o),
      .brake_o       (brake_o),
      .runlights_o   (runlights_o),
      .turn_state_o  (turn_state_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [6:0] mk(input logic l, input logic r, input logic h,
                                     input logic b, input logic rl,
                                     input logic [1:0] st);
      return {l, r, h, b, rl, st};
   endfunction

   task automatic push(input int dly, input logic [6:0] v, input string name);
      sb.push_back('{cyc + dly, v, name});
   endtask

   // ------------------------------------------------------------------------
   task automatic test_reset();
      exp_t e;
      for (int t = 0; t < 6; t++) begin
         @(negedge clk);
         while (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            checks++;
            if (outs !== e.exp) begin
               errors++;
               $display("FAIL %s: got %b required %b at cycle %0d", e.name, outs, e.exp, cyc);
            end
         end
         case (t)
            0: begin
               rst_n = 1'b0; stalk_left_i = 0; stalk_right_i = 0;
               hazard_btn_i = 0; brake_pedal_i = 0; headlight_sw_i = 0;
               push(1, 7'b0, "reset_state");
            end
            1: begin
               rst_n = 1'b1;
               push(1, 7'b0, "reset_release");
               push(4, 7'b0, "reset_idle");
            end
            default: ;
         endcase
      end
   endtask

   // ------------------------------------------------------------------------
   task automatic test_left();
      exp_t e;
      for (int t = 0; t < 18; t++) begin
         @(negedge clk);
         while (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            checks++;
            if (outs !== e.exp) begin
               errors++;
               $display("FAIL %s: got %b required %b at cycle %0d", e.name, outs, e.exp, cyc);
            end
         end
         case (t)
            0: begin
               stalk_left_i = 1'b1;
               push(1, 7'b0, "left_sync_quiet");
               push(6, 7'b0, "left_edge5");
               push(7, mk(1, 0, 0, 0, 0, 2'b01), "left_edge6");
            end
            9: begin
               stalk_left_i = 1'b0;
               push(6, mk(1, 0, 0, 0, 0, 2'b01), "left_release_edge5");
               push(7, 7'b0, "left_release_idle");
            end
            default: ;
         endcase
      end
   endtask

   // ------------------------------------------------------------------------
   task automatic test_hazard_bounce();
      exp_t e;
      for (int t = 0; t < 42; t++) begin
         @(negedge clk);
         while (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            checks++;
            if (outs !== e.exp) begin
               errors++;
               $display("FAIL %s: got %b required %b at cycle %0d", e.name, outs, e.exp, cyc);
            end
         end
         case (t)
            0: begin hazard_btn_i = 1'b1; push(1, 7'b0, "bounce_quiet"); end
            1: hazard_btn_i = 1'b0;
            2: hazard_btn_i = 1'b1;
            3: hazard_btn_i = 1'b0;
            4: begin
               hazard_btn_i = 1'b1;
               push(3, 7'b0, "bounce_no_toggle");
               push(6, 7'b0, "hazard_edge5");
               push(7, mk(0, 0, 1, 0, 0, 2'b00), "hazard_on");
               push(10, mk(0, 0, 1, 0, 0, 2'b00), "hazard_hold_single");
            end
            14: begin
               hazard_btn_i = 1'b0;
               push(8, mk(0, 0, 1, 0, 0, 2'b00), "hazard_release_no_toggle");
            end
            22: begin
               hazard_btn_i = 1'b1;
               push(6, mk(0, 0, 1, 0, 0, 2'b00), "hazard_press2_edge5");
               push(7, 7'b0, "hazard_off");
            end
            32: begin
               hazard_btn_i = 1'b0;
               push(8, 7'b0, "hazard_release2");
            end
            default: ;
         endcase
      end
   endtask

   // ------------------------------------------------------------------------
   task automatic test_lockout();
      exp_t e;
      for (int t = 0; t < 42; t++) begin
         @(negedge clk);
         while (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            checks++;
            if (outs !== e.exp) begin
               errors++;
               $display("FAIL %s: got %b required %b at cycle %0d", e.name, outs, e.exp, cyc);
            end
         end
         case (t)
            0: begin
               stalk_left_i = 1'b1;
               push(7, mk(1, 0, 0, 0, 0, 2'b01), "lock_left_on");
            end
            10: begin
               stalk_right_i = 1'b1;
               push(6, mk(1, 0, 0, 0, 0, 2'b01), "lock_before");
               push(7, mk(0, 0, 0, 0, 0, 2'b11), "lockout_enter");
            end
            20: begin
               stalk_right_i = 1'b0;
               push(7, mk(0, 0, 0, 0, 0, 2'b11), "lockout_right_released");
               push(10, mk(0, 0, 0, 0, 0, 2'b11), "lockout_hold");
            end
            32: begin
               stalk_left_i = 1'b0;
               push(6, mk(0, 0, 0, 0, 0, 2'b11), "lockout_exit_edge5");
               push(7, 7'b0, "lockout_exit_idle");
            end
            default: ;
         endcase
      end
   endtask

   // ------------------------------------------------------------------------
   task automatic test_hazard_suppress();
      exp_t e;
      for (int t = 0; t < 50; t++) begin
         @(negedge clk);
         while (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            checks++;
            if (outs !== e.exp) begin
               errors++;
               $display("FAIL %s: got %b required %b at cycle %0d", e.name, outs, e.exp, cyc);
            end
         end
         case (t)
            0: begin
               stalk_left_i = 1'b1;
               push(7, mk(1, 0, 0, 0, 0, 2'b01), "supp_left_on");
            end
            10: begin
               hazard_btn_i = 1'b1;
               push(6, mk(1, 0, 0, 0, 0, 2'b01), "supp_edge5");
               push(7, mk(0, 0, 1, 0, 0, 2'b01), "hazard_suppresses_left");
            end
            20: begin
               hazard_btn_i = 1'b0;
               push(8, mk(0, 0, 1, 0, 0, 2'b01), "supp_fsm_tracks");
            end
            30: begin
               hazard_btn_i = 1'b1;
               push(6, mk(0, 0, 1, 0, 0, 2'b01), "resume_edge5");
               push(7, mk(1, 0, 0, 0, 0, 2'b01), "turn_resume");
            end
            40: begin
               hazard_btn_i = 1'b0;
               stalk_left_i = 1'b0;
               push(7, 7'b0, "supp_all_off");
            end
            default: ;
         endcase
      end
   endtask

   // ------------------------------------------------------------------------
   task automatic test_brake_reset();
      exp_t e;
      for (int t = 0; t < 40; t++) begin
         @(negedge clk);
         while (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            checks++;
            if (outs !== e.exp) begin
               errors++;
               $display("FAIL %s: got %b required %b at cycle %0d", e.name, outs, e.exp, cyc);
            end
         end
         case (t)
            0: begin
               stalk_right_i = 1'b1;
               push(7, mk(0, 1, 0, 0, 0, 2'b10), "right_on");
            end
            10: begin
               brake_pedal_i = 1'b1;
               headlight_sw_i = 1'b1;
               push(6, mk(0, 1, 0, 0, 0, 2'b10), "brake_edge5");
               push(7, mk(0, 1, 0, 1, 1, 2'b10), "brake_runlights_on");
            end
            20: begin
               rst_n = 1'b0;
               push(1, 7'b0, "mid_reset");
            end
            21: begin
               rst_n = 1'b1;
               push(6, 7'b0, "post_reset_flushed");
               push(7, mk(0, 1, 0, 1, 1, 2'b10), "post_reset_recover");
            end
            30: begin
               stalk_right_i = 1'b0;
               brake_pedal_i = 1'b0;
               headlight_sw_i = 1'b0;
               push(7, 7'b0, "brake_all_off");
            end
            default: ;
         endcase
      end
   endtask

   // ------------------------------------------------------------------------
   task automatic test_long_hold();
      exp_t e;
      for (int t = 0; t < 52; t++) begin
         @(negedge clk);
         while (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            checks++;
            if (outs !== e.exp) begin
               errors++;
               $display("FAIL %s: got %b required %b at cycle %0d", e.name, outs, e.exp, cyc);
            end
         end
         case (t)
            0: begin
               stalk_right_i = 1'b1;
               push(7, mk(0, 1, 0, 0, 0, 2'b10), "hold_right_on");
`ifdef TAILLIGHT_STALK_CTRL_AUTOCANCEL_EN
               push(22, mk(0, 1, 0, 0, 0, 2'b10), "cancel_last_lit");
               push(23, mk(0, 0, 0, 0, 0, 2'b11), "autocancel_lockout");
`else
               push(23, mk(0, 1, 0, 0, 0, 2'b10), "hold_right_persist");
               push(40, mk(0, 1, 0, 0, 0, 2'b10), "hold_right_persist_long");
`endif
            end
            42: begin
               stalk_right_i = 1'b0;
`ifdef TAILLIGHT_STALK_CTRL_AUTOCANCEL_EN
               push(6, mk(0, 0, 0, 0, 0, 2'b11), "cancel_release_edge5");
`else
               push(6, mk(0, 1, 0, 0, 0, 2'b10), "hold_release_edge5");
`endif
               push(7, 7'b0, "hold_release_idle");
            end
            default: ;
         endcase
      end
   endtask

   // ------------------------------------------------------------------------
   initial begin
      rst_n          = 1'b0;
      stalk_left_i   = 1'b0;
      stalk_right_i  = 1'b0;
      hazard_btn_i   = 1'b0;
      brake_pedal_i  = 1'b0;
      headlight_sw_i = 1'b0;

      test_reset();
      test_left();
      test_hazard_bounce();
      test_lockout();
      test_hazard_suppress();
      test_brake_reset();
      test_long_hold();

      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d pending entries required 0", sb.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/taillight_stalk_ctrl.md
Name: taillight_stalk_ctrl

Overview:
Driver-side controller that generates the command inputs consumed by the taillight sequencer: left, right, hazard, brake and runlights.
- Takes raw, bouncing switch and button levels from the steering column and pedal.
- Synchronizes and debounces each input, then resolves turn-stalk conflicts.
- Converts the hazard push-button into a toggle.
- Drives clean, registered level outputs that connect 1:1 to the sequencer's `*_i` ports.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive stable synchronized samples required before a debounced level changes (min 1, max 255)
CANCEL_CYCLES, 16, turn-signal auto-cancel timeout in clk cycles (used only with the optional feature; min 1, max 65535)

Ports:
clk  input  1  system clock; all state updates on the rising edge
rst_n  input  1  synchronous, active-low reset
stalk_left_i  input  1  raw left turn-stalk level, asynchronous, may bounce
stalk_right_i  input  1  raw right turn-stalk level, asynchronous, may bounce
hazard_btn_i  input  1  raw hazard push-button level; 1 = pressed
brake_pedal_i  input  1  raw brake-pedal switch level
headlight_sw_i  input  1  raw headlight/runlight switch level
left_o  output  1  left turn command to the taillight sequencer
right_o  output  1  right turn command to the taillight sequencer
hazard_o  output  1  hazard command
brake_o  output  1  brake command
runlights_o  output  1  running-lights command
turn_state_o  output  2  FSM state: 00 IDLE, 01 LEFT, 10 RIGHT, 11 LOCKOUT

Behaviour:
Reset:
- rst_n is sampled at the rising clk edge only. When low, it overrides all other logic.
- On a reset edge, all synchronizer flops, debounced values, debounce counters, the hazard toggle and the auto-cancel counter clear to 0, and the FSM goes to IDLE.
- All outputs read 0 after the reset edge.
- A reset during any state or during a debounce count takes effect on that same edge; no partial state survives.

Synchronizer:
- Each raw input passes through a 2-flop synchronizer; sync2 is the second stage.

Debouncer (one per input):
- Holds a debounced value `deb` and a counter `cnt`.
- If sync2 == deb: cnt clears to 0.
- Otherwise: cnt increments. On the edge where cnt would reach DEBOUNCE_CYCLES, deb takes sync2 and cnt clears to 0.
- A bounce (sync2 returning to deb) before that edge clears cnt, and deb does not change.

Latency:
- Raw input clean-steps before edge k → deb changes at edge k+1+DEBOUNCE_CYCLES → the registered output changes at edge k+2+DEBOUNCE_CYCLES.
- With DEBOUNCE_CYCLES=4, this is 6 edges.

Hazard:
- hazard_q toggles on the cycle in which deb_hazard goes 0→1 (press edge only).
- Release does nothing; holding the button produces a single toggle.
- hazard_o = hazard_q, registered.

Brake and runlights:
- brake_o follows deb_brake; runlights_o follows deb_headlight.
- Both are registered and independent of the FSM and of hazard.

Turn FSM (evaluated on debounced left/right, dl/dr):
- IDLE: dl&!dr → LEFT; dr&!dl → RIGHT; both set or both clear → stay IDLE.
- LEFT: !dl → IDLE; dl&dr → LOCKOUT.
- RIGHT: !dr → IDLE; dl&dr → LOCKOUT.
- LOCKOUT: !dl&!dr → IDLE; otherwise stay. The stalk must fully return to centre before a new signal.

Turn outputs (registered):
- left_o = (state==LEFT) & !hazard_q.
- right_o = (state==RIGHT) & !hazard_q.
- While hazard is active, turn outputs are suppressed but the FSM keeps tracking. Turn outputs resume the cycle after hazard_q clears if the FSM is still in LEFT or RIGHT.
- left_o and right_o are never both 1.
- turn_state_o = current FSM state, registered alongside the other outputs.

Optional Feature:
Macro: TAILLIGHT_STALK_CTRL_AUTOCANCEL_EN
- Defined:
  - A 16-bit counter clears on each entry into LEFT or RIGHT and increments every cycle spent in that state.
  - When it reaches CANCEL_CYCLES, the FSM goes to LOCKOUT. The lamp turns off until both stalks are released.
  - Re-entering LEFT or RIGHT from LOCKOUT or IDLE restarts the count.
- Undefined:
  - No counter is instantiated. LEFT and RIGHT persist as long as the stalk is held.

Test Plan:
1. Reset, then raw stalk_left_i=1 held → left_o=1 exactly 6 edges later, turn_state_o=01, right_o=0, hazard_o=0 throughout.
2. Raw hazard_btn_i bounces 1,0,1,0 at single-cycle spacing, then settles at 1 for 10 cycles → hazard_o toggles exactly once to 1. A second clean press/release toggles it back to 0.
3. Left held (state LEFT), then raw right asserted → state LOCKOUT and left_o=right_o=0. Release right only → stays LOCKOUT. Release both → IDLE.
4. Hazard on while LEFT held → left_o=0, hazard_o=1, turn_state_o=01. Hazard off → left_o=1 on the next registered update.
5. brake_pedal_i=1 and headlight_sw_i=1 during an active right turn → brake_o=1 and runlights_o=1 after 6 edges, right_o unaffected. Then rst_n=0 for one edge → all outputs 0 and turn_state_o=00 after that edge.
6. With TAILLIGHT_STALK_CTRL_AUTOCANCEL_EN and CANCEL_CYCLES=16, right held continuously → right_o=1 for 16 cycles, then 0 with turn_state_o=11. Release → 00.
